pc_sequencer: RTL and testbench



---
 rtl/pc_sequencer.sv | 99 +++++++++
 tb/tb_pc_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program counter and run-control stage: start/done handshake, branch/jump
// sequencing and saturating performance counters.
module pc_sequencer #(
    parameter int PCW  = 10,
    parameter int CNTW = 16
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Start,
    input  logic [PCW-1:0]  StartAddr,
    input  logic            Stall,
    input  logic            Halt,
    input  logic            BranchEn,
    input  logic            Branch,
    input  logic            JumpEn,
    input  logic [PCW-1:0]  Target,
    output logic [PCW-1:0]  PC,
    output logic            Running,
    output logic            Done,
    output logic [CNTW-1:0] CycleCount,
    output logic [CNTW-1:0] TakenCount
);

    typedef enum logic [1:0] {IDLE, ARMED, RUN, DONE} state_t;

    localparam logic [CNTW-1:0] CNT_MAX = '1;
    localparam logic [CNTW-1:0] CNT_ONE = 1;
    localparam logic [PCW-1:0]  PC_ONE  = 1;

    state_t          state_q, state_d;
    logic [PCW-1:0]  pc_q, pc_d;
    logic [CNTW-1:0] cyc_q, cyc_d;
    logic [CNTW-1:0] tkn_q, tkn_d;
    logic            taken;

    // Gating Branch with BranchEn keeps an unknown condition out of the PC mux.
    assign taken = JumpEn | (BranchEn & Branch);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            cyc_q   <= '0;
            tkn_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cyc_q   <= cyc_d;
            tkn_q   <= tkn_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cyc_d   = cyc_q;
        tkn_d   = tkn_q;
        case (state_q)
            IDLE: begin
                if (Start) state_d = ARMED;
            end
            ARMED: begin
                pc_d  = StartAddr;
                cyc_d = '0;
                tkn_d = '0;
                if (!Start) state_d = RUN;
            end
            RUN: begin
                if (Start) begin
                    state_d = ARMED;
                end else begin
                    // Every non-restart RUN cycle counts, stalls and halt included.
                    if (cyc_q != CNT_MAX) cyc_d = cyc_q + CNT_ONE;
                    if (Stall) begin
                        pc_d = pc_q;
                    end else if (Halt) begin
                        state_d = DONE;
                    end else if (taken) begin
                        pc_d = Target;
                        if (tkn_q != CNT_MAX) tkn_d = tkn_q + CNT_ONE;
                    end else begin
                        pc_d = pc_q + PC_ONE;
                    end
                end
            end
            DONE: begin
                if (Start) state_d = ARMED;
            end
            default: state_d = IDLE;
        endcase
    end

    assign PC         = pc_q;
    assign Running    = (state_q == RUN);
    assign Done       = (state_q == DONE);
    assign CycleCount = cyc_q;
    assign TakenCount = tkn_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, async reset check, randomized
// run against a rule-level model, and counter saturation on a narrow instance.
module tb_pc_sequencer;

    localparam int PCW  = 10;
    localparam int CNTW = 16;

    logic            Clk = 0;
    logic            Reset;
    logic            Start, Stall, Halt, BranchEn, Branch, JumpEn;
    logic [PCW-1:0]  StartAddr, Target;
    logic [PCW-1:0]  PC;
    logic            Running, Done;
    logic [CNTW-1:0] CycleCount, TakenCount;

    logic            s_start, s_jen;
    logic [3:0]      s_addr, s_tgt, s_pc, s_cyc, s_tkn;
    logic            s_run, s_done;

    int n_chk = 0;
    int n_err = 0;

    always #5 Clk = ~Clk;

    pc_sequencer #(.PCW(PCW), .CNTW(CNTW)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr),
        .Stall(Stall), .Halt(Halt), .BranchEn(BranchEn), .Branch(Branch),
        .JumpEn(JumpEn), .Target(Target), .PC(PC), .Running(Running),
        .Done(Done), .CycleCount(CycleCount), .TakenCount(TakenCount)
    );

    pc_sequencer #(.PCW(4), .CNTW(4)) u_small (
        .Clk(Clk), .Reset(Reset), .Start(s_start), .StartAddr(s_addr),
        .Stall(1'b0), .Halt(1'b0), .BranchEn(1'b0), .Branch(1'b0),
        .JumpEn(s_jen), .Target(s_tgt), .PC(s_pc), .Running(s_run),
        .Done(s_done), .CycleCount(s_cyc), .TakenCount(s_tkn)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [PCW-1:0] pc, input logic run,
                           input logic done, input logic [CNTW-1:0] cyc, input logic [CNTW-1:0] tkn);
        chk({tag, ".PC"}, 32'(PC), 32'(pc));
        chk({tag, ".Running"}, 32'(Running), 32'(run));
        chk({tag, ".Done"}, 32'(Done), 32'(done));
        chk({tag, ".CycleCount"}, 32'(CycleCount), 32'(cyc));
        chk({tag, ".TakenCount"}, 32'(TakenCount), 32'(tkn));
    endtask

    task automatic idle_inputs();
        Start = 0; StartAddr = '0; Stall = 0; Halt = 0;
        BranchEn = 0; Branch = 0; JumpEn = 0; Target = '0;
    endtask

    typedef struct {
        logic           start;
        logic [PCW-1:0] addr;
        logic           stall, halt, ben, br, jen;
        logic [PCW-1:0] tgt;
        logic [PCW-1:0] pc;
        logic           run, done;
        int             cyc, tkn;
    } vec_t;

    vec_t vecs[24];

    // Reference model: run-state as a small integer, plain arithmetic per rule.
    localparam int M_IDLE = 0, M_ARMED = 1, M_RUN = 2, M_DONE = 3;
    int m_st, m_pc, m_cyc, m_tkn;

    function automatic int sat_inc(input int v);
        return (v >= (1 << CNTW) - 1) ? v : v + 1;
    endfunction

    task automatic model_step();
        case (m_st)
            M_IDLE:  if (Start) m_st = M_ARMED;
            M_ARMED: begin
                m_pc = int'(StartAddr); m_cyc = 0; m_tkn = 0;
                if (!Start) m_st = M_RUN;
            end
            M_RUN: begin
                if (Start) m_st = M_ARMED;
                else begin
                    m_cyc = sat_inc(m_cyc);
                    if (Stall) ;
                    else if (Halt) m_st = M_DONE;
                    else if (JumpEn || (BranchEn && Branch)) begin
                        m_pc = int'(Target); m_tkn = sat_inc(m_tkn);
                    end else m_pc = (m_pc + 1) % (1 << PCW);
                end
            end
            default: if (Start) m_st = M_ARMED;
        endcase
    endtask

    initial begin
        //          st  addr   stl hlt ben br jen tgt     pc    run dn cyc tkn
        vecs[0]  = '{1, 10'h010, 0, 0, 0, 0, 0, 10'h000, 10'h000, 0, 0, 0, 0};
        vecs[1]  = '{1, 10'h010, 0, 0, 0, 0, 0, 10'h000, 10'h010, 0, 0, 0, 0};
        vecs[2]  = '{1, 10'h010, 0, 0, 0, 0, 0, 10'h000, 10'h010, 0, 0, 0, 0};
        vecs[3]  = '{0, 10'h010, 0, 0, 0, 0, 0, 10'h000, 10'h010, 1, 0, 0, 0};
        vecs[4]  = '{0, 10'h000, 0, 0, 0, 0, 0, 10'h000, 10'h011, 1, 0, 1, 0};
        vecs[5]  = '{0, 10'h000, 0, 0, 0, 0, 0, 10'h000, 10'h012, 1, 0, 2, 0};
        vecs[6]  = '{0, 10'h000, 0, 0, 0, 0, 0, 10'h000, 10'h013, 1, 0, 3, 0};
        vecs[7]  = '{0, 10'h000, 0, 0, 0, 0, 0, 10'h000, 10'h014, 1, 0, 4, 0};
        vecs[8]  = '{0, 10'h000, 0, 1, 0, 0, 0, 10'h000, 10'h014, 0, 1, 5, 0};
        vecs[9]  = '{0, 10'h000, 0, 0, 0, 0, 1, 10'h123, 10'h014, 0, 1, 5, 0};
        vecs[10] = '{1, 10'h020, 0, 0, 0, 0, 0, 10'h000, 10'h014, 0, 0, 5, 0};
        vecs[11] = '{0, 10'h020, 0, 0, 0, 0, 0, 10'h000, 10'h020, 1, 0, 0, 0};
        vecs[12] = '{0, 10'h000, 0, 0, 1, 1, 0, 10'h100, 10'h100, 1, 0, 1, 1};
        vecs[13] = '{0, 10'h000, 0, 0, 1, 0, 0, 10'h200, 10'h101, 1, 0, 2, 1};
        vecs[14] = '{0, 10'h000, 0, 0, 1, 1, 1, 10'h030, 10'h030, 1, 0, 3, 2};
        vecs[15] = '{0, 10'h000, 1, 1, 0, 0, 1, 10'h100, 10'h030, 1, 0, 4, 2};
        vecs[16] = '{0, 10'h000, 0, 1, 0, 0, 0, 10'h000, 10'h030, 0, 1, 5, 2};
        vecs[17] = '{1, 10'h3FE, 0, 0, 0, 0, 0, 10'h000, 10'h030, 0, 0, 5, 2};
        vecs[18] = '{0, 10'h3FE, 0, 0, 0, 0, 0, 10'h000, 10'h3FE, 1, 0, 0, 0};
        vecs[19] = '{0, 10'h000, 0, 0, 0, 0, 0, 10'h000, 10'h3FF, 1, 0, 1, 0};
        vecs[20] = '{0, 10'h000, 0, 0, 0, 0, 0, 10'h000, 10'h000, 1, 0, 2, 0};
        vecs[21] = '{0, 10'h000, 0, 0, 0, 1, 0, 10'h000, 10'h001, 1, 0, 3, 0};
        vecs[22] = '{1, 10'h200, 0, 0, 0, 0, 0, 10'h000, 10'h001, 0, 0, 3, 0};
        vecs[23] = '{0, 10'h200, 0, 0, 0, 0, 0, 10'h000, 10'h200, 1, 0, 0, 0};

        idle_inputs();
        s_start = 0; s_jen = 0; s_addr = 4'h3; s_tgt = 4'h5;
        Reset = 1;
        @(negedge Clk); @(negedge Clk);
        chk_all("reset", '0, 0, 0, '0, '0);
        Reset = 0;

        for (int i = 0; i < 24; i++) begin
            Start = vecs[i].start; StartAddr = vecs[i].addr; Stall = vecs[i].stall;
            Halt = vecs[i].halt; BranchEn = vecs[i].ben; Branch = vecs[i].br;
            JumpEn = vecs[i].jen; Target = vecs[i].tgt;
            @(posedge Clk); @(negedge Clk);
            chk_all($sformatf("vec%0d", i), vecs[i].pc, vecs[i].run, vecs[i].done,
                    CNTW'(vecs[i].cyc), CNTW'(vecs[i].tkn));
        end

        // Asynchronous reset in the middle of a RUN cycle.
        idle_inputs();
        Start = 1; StartAddr = 10'h155;
        repeat (2) begin @(posedge Clk); @(negedge Clk); end
        Start = 0;
        @(posedge Clk); @(negedge Clk);
        chk("pre_reset.PC", 32'(PC), 32'h155);
        chk("pre_reset.Running", 32'(Running), 1);
        #2 Reset = 1;
        #1 chk_all("async_reset", '0, 0, 0, '0, '0);
        @(negedge Clk);
        Reset = 0;
        @(posedge Clk); @(negedge Clk);
        chk_all("idle_hold", '0, 0, 0, '0, '0);

        // Randomized run against the model, starting from the reset state.
        m_st = M_IDLE; m_pc = 0; m_cyc = 0; m_tkn = 0;
        for (int c = 0; c < 600; c++) begin
            if (m_st == M_RUN)        Start = ($urandom_range(0, 39) == 0);
            else if (m_st == M_ARMED) Start = ($urandom_range(0, 1) == 0);
            else                      Start = ($urandom_range(0, 2) == 0);
            StartAddr = PCW'($urandom);
            Stall     = ($urandom_range(0, 4) == 0);
            Halt      = ($urandom_range(0, 29) == 0);
            BranchEn  = ($urandom_range(0, 3) == 0);
            Branch    = 1'($urandom);
            JumpEn    = ($urandom_range(0, 7) == 0);
            Target    = PCW'($urandom);
            @(posedge Clk);
            model_step();
            @(negedge Clk);
            chk_all($sformatf("rand%0d", c), PCW'(m_pc), m_st == M_RUN, m_st == M_DONE,
                    CNTW'(m_cyc), CNTW'(m_tkn));
        end
        idle_inputs();

        // Saturation on the 4-bit-counter instance: 20 jump cycles in RUN.
        s_start = 1;
        repeat (2) @(posedge Clk);
        @(negedge Clk); s_start = 0;
        @(posedge Clk); @(negedge Clk);
        chk("small.start_pc", 32'(s_pc), 32'h3);
        chk("small.running", 32'(s_run), 1);
        s_jen = 1;
        repeat (20) @(posedge Clk);
        @(negedge Clk);
        chk("small.cyc_sat", 32'(s_cyc), 32'hF);
        chk("small.tkn_sat", 32'(s_tkn), 32'hF);
        chk("small.pc", 32'(s_pc), 32'h5);
        chk("small.still_run", 32'(s_run), 1);
        chk("small.done", 32'(s_done), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
